// File: rtl/line_burst_pkg.sv
// Shared types and constants for the line-to-burst adaptor.
// Line geometry, FSM state encoding and address alignment helper.
package line_burst_pkg;

   localparam int S_OFFSET  = 5;
   localparam int S_LINE    = 256;
   localparam int S_BEAT    = 64;
   localparam int NUM_BEATS = S_LINE / S_BEAT;
   localparam int CNT_W     = $clog2(NUM_BEATS);

   typedef enum logic [1:0] {
      IDLE     = 2'd0,
      RD_BURST = 2'd1,
      WR_BURST = 2'd2,
      DONE     = 2'd3
   } state_e;

   // A line viewed as beats; beat 0 occupies the least significant bits.
   typedef logic [NUM_BEATS-1:0][S_BEAT-1:0] line_t;

   function automatic logic [31:0] line_align(input logic [31:0] addr);
      return addr & ~((32'd1 << S_OFFSET) - 32'd1);
   endfunction

endpackage

// File: rtl/line_burst_adaptor.sv
// Turns one 256-bit line read/write request into a 4 x 64-bit memory burst.
// Optional LINE_BURST_ADAPTOR_PERF_EN adds hierarchical-only activity counters.
module line_burst_adaptor
   import line_burst_pkg::*;
(
   input  logic              clk,
   input  logic              rst,
   input  logic              line_read,
   input  logic              line_write,
   input  logic [31:0]       line_address,
   input  logic [S_LINE-1:0] line_wdata,
   output logic              line_resp,
   output logic [S_LINE-1:0] line_rdata,
   output logic              burst_read,
   output logic              burst_write,
   output logic [31:0]       burst_address,
   output logic [S_BEAT-1:0] burst_wdata,
   input  logic              burst_resp,
   input  logic [S_BEAT-1:0] burst_rdata
);

   localparam logic [1:0] ST_IDLE = IDLE;
   localparam logic [1:0] ST_RD   = RD_BURST;
   localparam logic [1:0] ST_WR   = WR_BURST;
   localparam logic [1:0] ST_DONE = DONE;

   logic [1:0]       state;
   logic [CNT_W-1:0] cnt;
   logic [31:0]      addr_q;
   line_t            line_buf;
   line_t            buf_next;
   line_t            rdata_q;
   logic             last_beat;

   assign last_beat = burst_resp && (cnt == CNT_W'(NUM_BEATS - 1));

   // line_buf holds the write line or the read line under assembly; the
   // completed read line is copied to rdata_q so line_rdata stays stable.
   always_comb begin
      buf_next = line_buf;
      if ((state == ST_RD) && burst_resp) begin
         buf_next[cnt] = burst_rdata;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state    <= ST_IDLE;
         cnt      <= '0;
         addr_q   <= '0;
         line_buf <= '0;
         rdata_q  <= '0;
      end else begin
         case (state)
            ST_IDLE: begin
               if (line_write) begin
                  addr_q   <= line_align(line_address);
                  line_buf <= line_wdata;
                  cnt      <= '0;
                  state    <= ST_WR;
               end else if (line_read) begin
                  addr_q <= line_align(line_address);
                  cnt    <= '0;
                  state  <= ST_RD;
               end
            end
            ST_RD: begin
               if (burst_resp) begin
                  line_buf <= buf_next;
                  cnt      <= cnt + CNT_W'(1);
                  if (last_beat) begin
                     rdata_q <= buf_next;
                     state   <= ST_DONE;
                  end
               end
            end
            ST_WR: begin
               if (burst_resp) begin
                  cnt <= cnt + CNT_W'(1);
                  if (last_beat) begin
                     state <= ST_DONE;
                  end
               end
            end
            default: begin
               state <= ST_IDLE;
            end
         endcase
      end
   end

   assign burst_read    = (state == ST_RD);
   assign burst_write   = (state == ST_WR);
   assign line_resp     = (state == ST_DONE);
   assign burst_address = addr_q;
   assign burst_wdata   = line_buf[cnt];
   assign line_rdata    = rdata_q;

`ifdef LINE_BURST_ADAPTOR_PERF_EN
   logic [31:0] read_count;
   logic [31:0] write_count;
   logic [31:0] busy_cycles;
   logic        op_write;

   // op_write only matters on the cycle IDLE accepts, where write has priority.
   always_ff @(posedge clk) begin
      if (rst) begin
         read_count  <= '0;
         write_count <= '0;
         busy_cycles <= '0;
         op_write    <= 1'b0;
      end else begin
         if (state == ST_IDLE) begin
            op_write <= line_write;
         end else begin
            busy_cycles <= busy_cycles + 32'd1;
         end
         if (state == ST_DONE) begin
            if (op_write) begin
               write_count <= write_count + 32'd1;
            end else begin
               read_count <= read_count + 32'd1;
            end
         end
      end
   end
`else
   // Counters are not built in this configuration.
`endif

endmodule

// File: tb/tb_line_burst_adaptor.sv
// Directed and randomized bench for line_burst_adaptor against a line-level model.
// Defining LINE_BURST_ADAPTOR_PERF_EN also checks the request counters.
`timescale 1ns/1ps
module tb_line_burst_adaptor;

   logic         clk = 1'b0;
   logic         rst;
   logic         line_read;
   logic         line_write;
   logic [31:0]  line_address;
   logic [255:0] line_wdata;
   logic         line_resp;
   logic [255:0] line_rdata;
   logic         burst_read;
   logic         burst_write;
   logic [31:0]  burst_address;
   logic [63:0]  burst_wdata;
   logic         burst_resp;
   logic [63:0]  burst_rdata;

   int total = 0;
   int bad   = 0;

   logic [63:0]  exp_q[$];
   logic [255:0] last_rd_line;
   int           exp_reads;
   int           exp_writes;

   always #5 clk = ~clk;

   line_burst_adaptor dut (
      .clk           (clk),
      .rst           (rst),
      .line_read     (line_read),
      .line_write    (line_write),
      .line_address  (line_address),
      .line_wdata    (line_wdata),
      .line_resp     (line_resp),
      .line_rdata    (line_rdata),
      .burst_read    (burst_read),
      .burst_write   (burst_write),
      .burst_address (burst_address),
      .burst_wdata   (burst_wdata),
      .burst_resp    (burst_resp),
      .burst_rdata   (burst_rdata)
   );

   task automatic check(input string tag, input logic [255:0] obs, input logic [255:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   function automatic logic [31:0] aligned(input logic [31:0] a);
      return a - (a % 32);
   endfunction

   function automatic logic [255:0] rand_line();
      logic [255:0] l;
      for (int k = 0; k < 8; k++) l[32*k +: 32] = $urandom;
      return l;
   endfunction

   // Memory side returns the beats of the line argument low beat first; gap[i] idle cycles precede beat i.
   task automatic do_read(input logic [31:0] addr, input logic [255:0] line,
                          input logic [3:0][3:0] gap, input string tag);
      line_read    = 1'b1;
      line_write   = 1'b0;
      line_address = addr;
      step();
      check({tag, ".rd_req"}, burst_read, 1);
      check({tag, ".rd_nowr"}, burst_write, 0);
      check({tag, ".rd_addr"}, burst_address, aligned(addr));
      line_address = $urandom;
      for (int i = 0; i < 4; i++) begin
         for (int g = 0; g < gap[i]; g++) begin
            burst_resp = 1'b0;
            step();
         end
         check({tag, ".rd_early"}, line_resp, 0);
         burst_resp  = 1'b1;
         burst_rdata = line[64*i +: 64];
         step();
      end
      burst_resp  = 1'b0;
      burst_rdata = 64'($urandom);
      check({tag, ".rd_resp"}, line_resp, 1);
      check({tag, ".rd_data"}, line_rdata, line);
      check({tag, ".rd_drop"}, burst_read, 0);
      last_rd_line = line;
      exp_reads++;
      line_read = 1'b0;
      step();
      check({tag, ".rd_pulse"}, line_resp, 0);
      check({tag, ".rd_hold"}, line_rdata, last_rd_line);
   endtask

   task automatic do_write(input logic [31:0] addr, input logic [255:0] line,
                           input logic [3:0][3:0] gap, input logic both, input string tag);
      line_write   = 1'b1;
      line_read    = both;
      line_address = addr;
      line_wdata   = line;
      for (int i = 0; i < 4; i++) exp_q.push_back(line[64*i +: 64]);
      step();
      check({tag, ".wr_req"}, burst_write, 1);
      check({tag, ".wr_nord"}, burst_read, 0);
      check({tag, ".wr_addr"}, burst_address, aligned(addr));
      line_wdata   = rand_line();
      line_address = $urandom;
      for (int i = 0; i < 4; i++) begin
         for (int g = 0; g < gap[i]; g++) begin
            burst_resp = 1'b0;
            step();
         end
         burst_resp = 1'b1;
         check({tag, ".wr_beat"}, burst_wdata, exp_q.pop_front());
         step();
      end
      burst_resp = 1'b0;
      check({tag, ".wr_drop"}, burst_write, 0);
      check({tag, ".wr_resp"}, line_resp, 1);
      exp_writes++;
      line_write = 1'b0;
      line_read  = 1'b0;
      step();
      check({tag, ".wr_pulse"}, line_resp, 0);
      check({tag, ".wr_rdata"}, line_rdata, last_rd_line);
   endtask

   initial begin
      logic [255:0]     l;
      logic [3:0][3:0]  gp;
      rst          = 1'b1;
      line_read    = 1'b0;
      line_write   = 1'b0;
      line_address = '0;
      line_wdata   = '0;
      burst_resp   = 1'b0;
      burst_rdata  = '0;
      last_rd_line = '0;
      exp_reads    = 0;
      exp_writes   = 0;
      step();
      step();
      rst = 1'b0;

      // Reset values.
      check("rst.line_resp", line_resp, 0);
      check("rst.burst_read", burst_read, 0);
      check("rst.burst_write", burst_write, 0);
      check("rst.burst_address", burst_address, 0);
      check("rst.burst_wdata", burst_wdata, 0);
      check("rst.line_rdata", line_rdata, 0);

      // Back-to-back read: response at cycle 5.
      l = {64'h4444_4444_4444_4444, 64'h3333_3333_3333_3333,
           64'h2222_2222_2222_2222, 64'h1111_1111_1111_1111};
      do_read(32'h0000_1234, l, '0, "rd_b2b");
      check("rd_b2b.addr_const", aligned(32'h0000_1234), 32'h0000_1220);

      // Write with beats A..D.
      l = {64'hDDDD_DDDD_DDDD_DDDD, 64'hCCCC_CCCC_CCCC_CCCC,
           64'hBBBB_BBBB_BBBB_BBBB, 64'hAAAA_AAAA_AAAA_AAAA};
      do_write(32'hABCD_0040, l, '0, 1'b0, "wr_abcd");

      // Read with three idle cycles before beat 2: response at cycle 8.
      gp = '0;
      gp[2] = 4'd3;
      do_read(32'h0000_2000, rand_line(), gp, "rd_gap");

      // Simultaneous read and write: write wins.
      do_write(32'h0000_0100, rand_line(), '0, 1'b1, "both");

      // Reset after two read beats.
      line_read    = 1'b1;
      line_address = 32'h0000_3000;
      step();
      for (int i = 0; i < 2; i++) begin
         burst_resp  = 1'b1;
         burst_rdata = 64'({$urandom, $urandom});
         step();
      end
      burst_resp = 1'b0;
      rst        = 1'b1;
      step();
      check("midrst.burst_read", burst_read, 0);
      check("midrst.line_resp", line_resp, 0);
      check("midrst.line_rdata", line_rdata, 0);
      last_rd_line = '0;
      exp_reads    = 0;
      exp_writes   = 0;
      rst          = 1'b0;
      line_read    = 1'b0;
      step();
      check("midrst.idle", burst_read, 0);
      do_read(32'h0000_3000, rand_line(), '0, "after_rst");

      // Stray beat strobes while idle.
      for (int i = 0; i < 3; i++) begin
         burst_resp  = 1'b1;
         burst_rdata = 64'({$urandom, $urandom});
         step();
         check("idle.burst_read", burst_read, 0);
         check("idle.burst_write", burst_write, 0);
         check("idle.line_resp", line_resp, 0);
         check("idle.line_rdata", line_rdata, last_rd_line);
      end
      burst_resp = 1'b0;
      do_read(32'h0000_4020, rand_line(), '0, "idle_after");
      do_write(32'h0000_5000, rand_line(), '0, 1'b0, "idle_after");

      // Randomized mix of requests, addresses, data and beat stalls.
      for (int n = 0; n < 24; n++) begin
         for (int i = 0; i < 4; i++) gp[i] = 4'($urandom_range(0, 2));
         if ($urandom_range(0, 1) == 1) do_write($urandom, rand_line(), gp, 1'($urandom_range(0, 1)), "rnd");
         else do_read($urandom, rand_line(), gp, "rnd");
      end

`ifdef LINE_BURST_ADAPTOR_PERF_EN
      check("perf.read_count", dut.read_count, 32'(exp_reads));
      check("perf.write_count", dut.write_count, 32'(exp_writes));
`endif

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/line_burst_adaptor.md
Name: line_burst_adaptor

Overview:
- Responder for the cache downstream line interface: accepts 256-bit line read/write requests from the last-level cache core.
- Converts each request into a 4-beat x 64-bit burst on the physical-memory side, then returns a single-cycle line response.
- Sits between the cache hierarchy's lowest cache and the physical memory model.
- Serves one request at a time, with no buffering of a second request.

Parameters:
- s_offset, 5, line offset bits; burst_address low s_offset bits are forced to 0.
- s_line, 256, line width in bits.
- s_beat, 64, burst beat width in bits.
- num_beats, s_line/s_beat (4), beats per burst; must be a power of 2.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  synchronous, active-high reset.
- line_read  in  1  line read request; held high until line_resp.
- line_write  in  1  line write request; held high until line_resp.
- line_address  in  32  line request address.
- line_wdata  in  s_line  write line data, sampled at accept.
- line_resp  out  1  one-cycle completion pulse.
- line_rdata  out  s_line  assembled read line; valid when line_resp is high, held until the next read completes.
- burst_read  out  1  memory burst read request.
- burst_write  out  1  memory burst write request.
- burst_address  out  32  line-aligned burst address.
- burst_wdata  out  s_beat  current write beat.
- burst_resp  in  1  memory beat strobe; one per beat.
- burst_rdata  in  s_beat  read beat data, valid with burst_resp.

Behaviour:
- Reset state: IDLE. All of the following are 0 after reset: line_resp, burst_read, burst_write, burst_address, burst_wdata, line_rdata, and the beat counter.
- FSM states: IDLE, RD_BURST, WR_BURST, DONE.
- IDLE:
  - If line_write is high: latch {line_address[31:s_offset], 0s} and line_wdata, clear the counter, go to WR_BURST.
  - Else if line_read is high: latch the address, clear the counter, go to RD_BURST.
  - Write wins if both are asserted.
  - burst_resp is ignored.
- RD_BURST:
  - burst_read = 1; burst_address = latched address.
  - On each burst_resp: store burst_rdata into line beat [counter] (beat 0 = bits 63:0, little-endian beat order) and increment the counter.
  - On burst_resp with counter == num_beats-1, go to DONE.
- WR_BURST:
  - burst_write = 1; burst_wdata = latched line beat [counter], combinational from registers.
  - On each burst_resp, advance the counter.
  - On the last beat, go to DONE.
- DONE: line_resp = 1 for exactly one cycle; burst_read and burst_write = 0; then go to IDLE.
  - A request still held in the cycle after DONE is treated as a new request.
  - Upstream must drop the request on line_resp.
- Counter: log2(num_beats) bits, wraps naturally. burst_resp outside a burst state has no effect.
- Latency:
  - Request at cycle 0 gives burst_read/burst_write at cycle 1.
  - With back-to-back beats at cycles 1-4, line_resp is at cycle 5.
  - Minimum 5 cycles; each burst_resp stall cycle adds one.
- line_address and line_wdata changes after accept have no effect on the in-flight burst.
- Reset mid-burst: return to IDLE next edge. burst_read/burst_write drop and the partial line is discarded; line_rdata is cleared to 0.
- No combinational path from line_* inputs to any output. Outputs are state- or register-derived; burst_wdata is a mux of registers.

Optional Feature:
- Macro LINE_BURST_ADAPTOR_PERF_EN.
- Defined: three internal 32-bit counters, read_count, write_count and busy_cycles, reset to 0 by rst.
  - read_count and write_count increment in DONE by request type.
  - busy_cycles increments every cycle not in IDLE.
  - All three wrap at 2^32 and are readable hierarchically only; there are no ports.
- Undefined: no counter logic is instantiated; port list and timing are identical.

Decomposition:
- Package line_burst_pkg: state enum (IDLE, RD_BURST, WR_BURST, DONE), constants S_LINE=256, S_BEAT=64, NUM_BEATS=4, S_OFFSET=5.
- Single module, no sub-module.
- A beat-indexed line register with write-enable per beat is small enough to stay inline.

Test Plan:
- Read 0x0000_1234, memory returns beats 0x11..11, 0x22..22, 0x33..33, 0x44..44 back-to-back:
  - burst_address = 0x0000_1220.
  - line_resp at cycle 5 with line_rdata = {44..,33..,22..,11..}.
- Write 0xABCD_0040 with line_wdata = {D,C,B,A} (64-bit beats):
  - burst_wdata sequence is A, B, C, D on successive burst_resp.
  - burst_write drops in the cycle after the 4th beat.
  - line_resp is a single pulse.
- Read with a burst_resp gap of 3 idle cycles between beats 1 and 2: line_resp at cycle 8; data is correct.
- line_read and line_write both high at 0x100: WR_BURST taken, then burst_write=1 and burst_read=0.
- rst asserted after beat 2 of a read: next cycle burst_read=0, line_resp=0, line_rdata=0. A following read then completes normally.
- burst_resp pulsed while IDLE: no state change and line_rdata unchanged. With LINE_BURST_ADAPTOR_PERF_EN, after 2 reads and 1 write: read_count=2, write_count=1.
